// File: rtl/map_table_if.sv
// Shared rename types and the dispatch/CDB/AMT bundle that connects to the map table.
package map_table_pkg;
    localparam int unsigned DP_NUM    = 2;
    localparam int unsigned MT_ENTRY  = 32;
    localparam int unsigned CDB_NUM   = 2;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned MT_IDX_W  = 5;
    localparam int unsigned ROB_IDX_W = 6;
    localparam int unsigned THREAD_W  = 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [THREAD_W-1:0]  thread_id;
        logic                 br_result;
    } cdb_t;

    typedef struct packed {
        logic [MT_IDX_W-1:0] rs1;
        logic [MT_IDX_W-1:0] rs2;
        logic                read_en;
        logic [THREAD_W-1:0] thread_idx;
    } dp_mt_read_t;

    typedef struct packed {
        logic [MT_IDX_W-1:0] rd;
        logic [TAG_W-1:0]    tag;
        logic                write_en;
        logic [THREAD_W-1:0] thread_idx;
    } dp_mt_write_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
    } amt_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag1;
        logic             tag1_ready;
        logic [TAG_W-1:0] tag2;
        logic             tag2_ready;
        logic [TAG_W-1:0] tag_old;
    } mt_dp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ready;
    } mt_entry_t;
endpackage

interface map_table_if;
    import map_table_pkg::*;

    logic         rollback;
    cdb_t         cdb      [CDB_NUM];
    dp_mt_read_t  dp_read  [DP_NUM];
    dp_mt_write_t dp_write [DP_NUM];
    amt_entry_t   amt      [MT_ENTRY];
    mt_dp_t       mp_dp_c  [DP_NUM];

    modport master (
        output rollback, cdb, dp_read, dp_write, amt,
        input  mp_dp_c
    );

    modport slave (
        input  rollback, cdb, dp_read, dp_write, amt,
        output mp_dp_c
    );
endinterface

// File: rtl/map_table.sv
// Register-rename map table: arch reg -> {physical tag, ready}, with zero-latency
// source/old-tag lookup, intra-bundle forwarding, CDB wakeup and AMT rollback.
module map_table
    import map_table_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    map_table_if.slave mt
);

    mt_entry_t table_q [MT_ENTRY];
    mt_entry_t table_d [MT_ENTRY];
    mt_dp_t    rd_out  [DP_NUM];
    logic      unused_fields;

    // Lookup: table state, overridden by older same-bundle writes, then CDB bypass
    always_comb begin
        for (int unsigned k = 0; k < DP_NUM; k++) begin
            rd_out[k].tag1       = table_q[mt.dp_read[k].rs1].tag;
            rd_out[k].tag1_ready = table_q[mt.dp_read[k].rs1].ready;
            rd_out[k].tag2       = table_q[mt.dp_read[k].rs2].tag;
            rd_out[k].tag2_ready = table_q[mt.dp_read[k].rs2].ready;
            rd_out[k].tag_old    = table_q[mt.dp_write[k].rd].tag;
            for (int unsigned j = 0; j < k; j++) begin
                if (mt.dp_write[j].write_en) begin
                    if (mt.dp_write[j].rd == mt.dp_read[k].rs1) begin
                        rd_out[k].tag1       = mt.dp_write[j].tag;
                        rd_out[k].tag1_ready = 1'b0;
                    end
                    if (mt.dp_write[j].rd == mt.dp_read[k].rs2) begin
                        rd_out[k].tag2       = mt.dp_write[j].tag;
                        rd_out[k].tag2_ready = 1'b0;
                    end
                    if (mt.dp_write[j].rd == mt.dp_write[k].rd) begin
                        rd_out[k].tag_old = mt.dp_write[j].tag;
                    end
                end
            end
            for (int unsigned c = 0; c < CDB_NUM; c++) begin
                if (mt.cdb[c].valid && (mt.cdb[c].tag == rd_out[k].tag1)) begin
                    rd_out[k].tag1_ready = 1'b1;
                end
                if (mt.cdb[c].valid && (mt.cdb[c].tag == rd_out[k].tag2)) begin
                    rd_out[k].tag2_ready = 1'b1;
                end
            end
        end
    end

    assign mt.mp_dp_c = rd_out;

    // Next state: CDB wakeup first so a same-cycle dispatch write overrides it
    always_comb begin
        table_d = table_q;
        for (int unsigned e = 0; e < MT_ENTRY; e++) begin
            for (int unsigned c = 0; c < CDB_NUM; c++) begin
                if (mt.cdb[c].valid && (mt.cdb[c].tag == table_q[e].tag)) begin
                    table_d[e].ready = 1'b1;
                end
            end
        end
        for (int unsigned k = 0; k < DP_NUM; k++) begin
            if (mt.dp_write[k].write_en) begin
                table_d[mt.dp_write[k].rd] = '{tag: mt.dp_write[k].tag, ready: 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MT_ENTRY; i++) begin
                table_q[i] <= '{tag: TAG_W'(i), ready: 1'b1};
            end
        end else if (mt.rollback) begin
            for (int unsigned i = 0; i < MT_ENTRY; i++) begin
                table_q[i] <= '{tag: mt.amt[i].tag, ready: 1'b1};
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Single-thread core: thread, ROB and branch fields are carried but not used here
    always_comb begin
        unused_fields = 1'b0;
        for (int unsigned c = 0; c < CDB_NUM; c++) begin
            unused_fields = unused_fields ^ (^{mt.cdb[c].rob_idx, mt.cdb[c].thread_id,
                                               mt.cdb[c].br_result});
        end
        for (int unsigned k = 0; k < DP_NUM; k++) begin
            unused_fields = unused_fields ^ (^{mt.dp_read[k].read_en, mt.dp_read[k].thread_idx,
                                               mt.dp_write[k].thread_idx});
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Directed self-checking bench for map_table.
module tb_map_table;
    import map_table_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    map_table_if mt ();

    map_table dut (
        .clk (clk),
        .rst (rst),
        .mt  (mt.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int k,
                              input int t1, input int r1,
                              input int t2, input int r2, input int told);
        check({tag, ".tag1"},    32'(mt.mp_dp_c[k].tag1),       32'(t1));
        check({tag, ".rdy1"},    32'(mt.mp_dp_c[k].tag1_ready), 32'(r1));
        check({tag, ".tag2"},    32'(mt.mp_dp_c[k].tag2),       32'(t2));
        check({tag, ".rdy2"},    32'(mt.mp_dp_c[k].tag2_ready), 32'(r2));
        check({tag, ".tag_old"}, 32'(mt.mp_dp_c[k].tag_old),    32'(told));
    endtask

    task automatic set_slot(input int k, input int rs1, input int rs2,
                            input int rd, input int tag, input logic we);
        mt.dp_read[k]  = '{rs1: MT_IDX_W'(rs1), rs2: MT_IDX_W'(rs2), read_en: 1'b1, thread_idx: '0};
        mt.dp_write[k] = '{rd: MT_IDX_W'(rd), tag: TAG_W'(tag), write_en: we, thread_idx: '0};
    endtask

    task automatic set_cdb(input int c, input logic v, input int tag);
        mt.cdb[c] = '{valid: v, tag: TAG_W'(tag), rob_idx: '0, thread_id: '0, br_result: 1'b0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        mt.rollback = 1'b0;
        for (int c = 0; c < CDB_NUM; c++) set_cdb(c, 1'b0, 0);
        for (int k = 0; k < DP_NUM; k++) set_slot(k, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < MT_ENTRY; i++) mt.amt[i] = '{tag: '0};

        // 1: identity mapping after reset
        do_reset();
        set_slot(0, 0, 5, 0, 0, 1'b0);
        set_slot(1, 7, 8, 0, 0, 1'b0);
        #1;
        check_slot("t1.s0", 0, 0, 1, 5, 1, 0);
        check_slot("t1.s1", 1, 7, 1, 8, 1, 0);

        // 2: reads see pre-write mapping, tag_old from table
        set_slot(0, 0, 5, 0, 32, 1'b1);
        set_slot(1, 7, 8, 7, 37, 1'b1);
        #1;
        check_slot("t2.s0", 0, 0, 1, 5, 1, 0);
        check_slot("t2.s1", 1, 7, 1, 8, 1, 7);

        // 3: self-overlapping rename, then the new mapping is visible and not ready
        do_reset();
        set_slot(0, 7, 7, 7, 32, 1'b1);
        set_slot(1, 8, 8, 8, 37, 1'b1);
        #1;
        check_slot("t3.s0", 0, 7, 1, 7, 1, 7);
        check_slot("t3.s1", 1, 8, 1, 8, 1, 8);
        @(negedge clk);
        set_slot(0, 7, 8, 0, 0, 1'b0);
        set_slot(1, 5, 6, 0, 0, 1'b0);
        #1;
        check_slot("t3b.s0", 0, 32, 0, 37, 0, 0);
        check_slot("t3b.s1", 1, 5, 1, 6, 1, 0);

        // 4: CDB bypass in the same cycle, then stored ready
        set_cdb(0, 1'b1, 32);
        set_cdb(1, 1'b1, 37);
        #1;
        check_slot("t4.s0", 0, 32, 1, 37, 1, 0);
        @(negedge clk);
        set_cdb(0, 1'b0, 0);
        set_cdb(1, 1'b0, 0);
        #1;
        check_slot("t4b.s0", 0, 32, 1, 37, 1, 0);

        // 5: intra-bundle forwarding of source and old tag
        set_slot(0, 1, 2, 3, 40, 1'b1);
        set_slot(1, 3, 5, 3, 41, 1'b1);
        #1;
        check_slot("t5.s0", 0, 1, 1, 2, 1, 3);
        check_slot("t5.s1", 1, 40, 0, 5, 1, 40);
        @(negedge clk);
        set_slot(0, 3, 3, 0, 0, 1'b0);
        set_slot(1, 0, 0, 0, 0, 1'b0);
        #1;
        check_slot("t5b.s0", 0, 41, 0, 41, 0, 0);

        // 5c: write to an entry wins over a same-cycle CDB wakeup of its old tag
        set_slot(0, 3, 3, 3, 41, 1'b1);
        set_cdb(0, 1'b1, 41);
        #1;
        check("t5c.bypass", 32'(mt.mp_dp_c[0].tag1_ready), 32'd1);
        @(negedge clk);
        set_cdb(0, 1'b0, 0);
        set_slot(0, 3, 3, 0, 0, 1'b0);
        #1;
        check("t5c.tag", 32'(mt.mp_dp_c[0].tag1), 32'd41);
        check("t5c.rdy", 32'(mt.mp_dp_c[0].tag1_ready), 32'd0);

        // 6: rollback restores AMT and discards the same-cycle dispatch write
        for (int i = 0; i < MT_ENTRY; i++) mt.amt[i] = '{tag: TAG_W'(i + 32)};
        mt.rollback = 1'b1;
        set_slot(0, 0, 0, 4, 50, 1'b1);
        @(negedge clk);
        mt.rollback = 1'b0;
        set_slot(0, 4, 3, 0, 0, 1'b0);
        #1;
        check_slot("t6.s0", 0, 36, 1, 35, 1, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
